// File: rtl/byte_deframer_2b_if.sv
// rtl/byte_deframer_2b_if.sv - symbol-in / byte-out bundle for byte_deframer_2b
//
// Purpose: groups the 2-bit symbol input and the byte output of the deframer.
// Signals:
//   data_in   [1:0]  symbol from the upstream mux, MSB pair of a byte first
//   valid_in         data_in carries a valid symbol this cycle
//   data_out  [7:0]  last assembled byte, holds between strobes
//   valid_out        one-cycle strobe, data_out is new this cycle
//   active           lock achieved, sticky until reset
// Modports:
//   master  upstream side (drives symbols, observes the byte output)
//   slave   deframer side
interface byte_deframer_2b_if;
  logic [1:0] data_in;
  logic       valid_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  modport master (output data_in, output valid_in,
                  input data_out, input valid_out, input active);
  modport slave  (input data_in, input valid_in,
                  output data_out, output valid_out, output active);
endinterface

// File: rtl/byte_deframer_2b.sv
// rtl/byte_deframer_2b.sv - 2-bit symbol to byte deframer with sync-byte lock
//
// Purpose: collects 2-bit symbols MSB pair first, slides a byte window until
// it matches SYNC_BYTE, confirms SYNC_COUNT consecutive aligned sync bytes,
// then emits every aligned byte with a one-cycle valid_out strobe.
// Ports:
//   clk      clock, all state changes on the rising edge
//   reset_L  asynchronous active-low reset
//   bus      byte_deframer_2b_if.slave (data_in, valid_in, data_out,
//            valid_out, active)
// Parameters:
//   SYNC_BYTE   alignment pattern (default 8'hBC)
//   SYNC_COUNT  aligned sync bytes required for lock, 1..15 (default 4)
// Build option:
//   DROP_SYNC_EN  when defined, aligned bytes equal to SYNC_BYTE are not
//                 emitted once locked
module byte_deframer_2b #(
  parameter logic [7:0] SYNC_BYTE  = 8'hBC,
  parameter int         SYNC_COUNT = 4
) (
  input logic                 clk,
  input logic                 reset_L,
  byte_deframer_2b_if.slave   bus
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [3:0] SYNC_TARGET = 4'(SYNC_COUNT);

  state_t     state_q, state_d;
  logic [5:0] shift_q, shift_d;
  logic [1:0] sym_cnt_q, sym_cnt_d;
  logic [3:0] sync_cnt_q, sync_cnt_d;
  logic [7:0] data_out_q, data_out_d;
  logic       valid_out_q, valid_out_d;
  logic       active_q, active_d;

  logic [7:0] window;
  logic [3:0] sync_inc;

  // Current candidate byte: the previous three valid symbols plus this one.
  assign window   = {shift_q, bus.data_in};
  assign sync_inc = sync_cnt_q + 4'd1;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= SEARCH;
      shift_q     <= '0;
      sym_cnt_q   <= '0;
      sync_cnt_q  <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      sym_cnt_q   <= sym_cnt_d;
      sync_cnt_q  <= sync_cnt_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      active_q    <= active_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    sym_cnt_d   = sym_cnt_q;
    sync_cnt_d  = sync_cnt_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    active_d    = active_q;

    // Idle cycles freeze everything; only the strobe drops back to 0.
    if (bus.valid_in) begin
      shift_d   = window[5:0];
      sym_cnt_d = sym_cnt_q + 2'd1;

      case (state_q)
        SEARCH: begin
          // Byte phase is defined by the matching window, so restart at 0.
          sym_cnt_d = '0;
          if (window == SYNC_BYTE) begin
            sync_cnt_d = 4'd1;
            if (SYNC_TARGET == 4'd1) begin
              state_d  = ACTIVE;
              active_d = 1'b1;
            end else begin
              state_d = ALIGN;
            end
          end
        end

        ALIGN: begin
          if (sym_cnt_q == 2'd3) begin
            if (window == SYNC_BYTE) begin
              sync_cnt_d = sync_inc;
              if (sync_inc == SYNC_TARGET) begin
                state_d  = ACTIVE;
                active_d = 1'b1;
              end
            end else begin
              // The failed window is not re-tested; sliding resumes next symbol.
              sync_cnt_d = '0;
              state_d    = SEARCH;
            end
          end
        end

        ACTIVE: begin
          if (sym_cnt_q == 2'd3) begin
`ifdef DROP_SYNC_EN
            if (window != SYNC_BYTE) begin
              data_out_d  = window;
              valid_out_d = 1'b1;
            end
`else
            data_out_d  = window;
            valid_out_d = 1'b1;
`endif
          end
        end

        default: begin
          state_d = SEARCH;
        end
      endcase
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.valid_out = valid_out_q;
  assign bus.active    = active_q;

endmodule

// File: tb/tb_byte_deframer_2b.sv
// tb/tb_byte_deframer_2b.sv - self-checking bench for byte_deframer_2b
module tb_byte_deframer_2b;

  localparam logic [7:0] SYNC       = 8'hBC;
  localparam int         SYNC_COUNT = 4;

  logic clk = 1'b0;
  logic reset_L = 1'b0;
  always #5 clk = ~clk;

  byte_deframer_2b_if bus ();

  byte_deframer_2b dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       v;
    logic [1:0] d;
    logic       ev;
    logic [7:0] ed;
    logic       ea;
  } vec_t;

  vec_t tbl[$];

  // Reference model: symbol history since reset plus index bookkeeping.
  logic [1:0] hist[$];
  int         anchor;
  int         matched;
  int         lock_at;
  logic       m_valid;
  logic       m_active;
  logic [7:0] m_data;

  int         strobes;
  logic [7:0] last_data;
  logic [7:0] first_data;
  logic       prev_valid;

  task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, got, exp);
    end
  endtask

  function automatic logic [1:0] sym_of(input logic [7:0] b, input int p);
    logic [7:0] t;
    t = b >> (6 - 2 * p);
    return t[1:0];
  endfunction

  task automatic model_reset();
    hist.delete();
    anchor     = -1;
    matched    = 0;
    lock_at    = -1;
    m_valid    = 1'b0;
    m_active   = 1'b0;
    m_data     = 8'h00;
    prev_valid = 1'b0;
  endtask

  task automatic model_symbol(input logic v, input logic [1:0] d);
    int k;
    int idx;
    logic [7:0] win;
    m_valid = 1'b0;
    if (v) begin
      hist.push_back(d);
      k   = hist.size() - 1;
      win = 8'h00;
      for (int i = 0; i < 4; i++) begin
        idx = k - 3 + i;
        if (idx >= 0) win = {win[5:0], hist[idx]};
        else          win = {win[5:0], 2'b00};
      end
      if (lock_at >= 0) begin
        if ((k - lock_at) % 4 == 0) begin
`ifdef DROP_SYNC_EN
          if (win != SYNC) begin
            m_valid = 1'b1;
            m_data  = win;
          end
`else
          m_valid = 1'b1;
          m_data  = win;
`endif
        end
      end else if (anchor < 0) begin
        if (win == SYNC) begin
          anchor  = k;
          matched = 1;
          if (matched == SYNC_COUNT) begin
            lock_at  = k;
            m_active = 1'b1;
          end
        end
      end else if ((k - anchor) % 4 == 0) begin
        if (win == SYNC) begin
          matched++;
          if (matched == SYNC_COUNT) begin
            lock_at  = k;
            m_active = 1'b1;
          end
        end else begin
          anchor  = -1;
          matched = 0;
        end
      end
    end
  endtask

  task automatic step(input logic v, input logic [1:0] d);
    bus.valid_in = v;
    bus.data_in  = d;
    @(posedge clk);
    model_symbol(v, d);
    #1;
    chk1("valid_out", bus.valid_out, m_valid);
    chk8("data_out", bus.data_out, m_data);
    chk1("active", bus.active, m_active);
    chk1("no_back_to_back", prev_valid & bus.valid_out, 1'b0);
    prev_valid = bus.valid_out;
    if (bus.valid_out) begin
      if (strobes == 0) first_data = bus.data_out;
      strobes++;
      last_data = bus.data_out;
    end
    bus.valid_in = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    for (int p = 0; p < 4; p++) begin
      step(1'b1, sym_of(b, p));
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        repeat ($urandom_range(1, 3)) step(1'b0, 2'(($urandom_range(0, 3))));
      end
    end
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    #1;
    model_reset();
    chk8("rst_data_out", bus.data_out, 8'h00);
    chk1("rst_valid_out", bus.valid_out, 1'b0);
    chk1("rst_active", bus.active, 1'b0);
    @(posedge clk);
    #1;
    reset_L    = 1'b1;
    strobes    = 0;
    last_data  = 8'h00;
    first_data = 8'h00;
  endtask

  task automatic add_vec(input logic v, input logic [1:0] d, input logic ev,
                         input logic [7:0] ed, input logic ea);
    vec_t e;
    e.v  = v;
    e.d  = d;
    e.ev = ev;
    e.ed = ed;
    e.ea = ea;
    tbl.push_back(e);
  endtask

  initial begin
    logic [7:0] b5a;
    bus.valid_in = 1'b0;
    bus.data_in  = 2'b00;
    strobes      = 0;
    last_data    = 8'h00;
    first_data   = 8'h00;
    model_reset();

    // Basic lock vectors: idle, 4x sync, 0x5A, idle.
    b5a = 8'h5A;
    add_vec(1'b0, 2'b00, 1'b0, 8'h00, 1'b0);
    for (int j = 0; j < 16; j++)
      add_vec(1'b1, sym_of(SYNC, j % 4), 1'b0, 8'h00, (j == 15));
    for (int p = 0; p < 4; p++)
      add_vec(1'b1, sym_of(b5a, p), (p == 3), (p == 3) ? 8'h5A : 8'h00, 1'b1);
    add_vec(1'b0, 2'b00, 1'b0, 8'h5A, 1'b1);

    #12;
    chk8("reset_data_out", bus.data_out, 8'h00);
    chk1("reset_valid_out", bus.valid_out, 1'b0);
    chk1("reset_active", bus.active, 1'b0);
    @(posedge clk);
    #1;
    reset_L = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].d);
      chk1("tbl_valid_out", bus.valid_out, tbl[i].ev);
      chk8("tbl_data_out", bus.data_out, tbl[i].ed);
      chk1("tbl_active", bus.active, tbl[i].ea);
    end

    // Misalignment: one leading symbol shifts the byte boundary.
    do_reset();
    step(1'b1, 2'd1);
    repeat (4) send_byte(SYNC, 1'b0);
    chk1("misalign_active", bus.active, 1'b1);
    send_byte(8'h3C, 1'b0);
    step(1'b0, 2'd0);
    chk8("misalign_strobes", 8'(strobes), 8'd1);
    chk8("misalign_data", last_data, 8'h3C);

    // Broken sync: a bad byte after two syncs restarts the count.
    do_reset();
    send_byte(SYNC, 1'b0);
    send_byte(SYNC, 1'b0);
    send_byte(8'h00, 1'b0);
    repeat (3) send_byte(SYNC, 1'b0);
    chk1("broken_not_active", bus.active, 1'b0);
    send_byte(SYNC, 1'b0);
    chk1("broken_active", bus.active, 1'b1);
    send_byte(8'hA5, 1'b0);
    step(1'b0, 2'd0);
    chk8("broken_strobes", 8'(strobes), 8'd1);
    chk8("broken_data", last_data, 8'hA5);

    // Gaps: idle cycles between symbols must not change the outcome.
    do_reset();
    repeat (4) send_byte(SYNC, 1'b1);
    chk1("gaps_active", bus.active, 1'b1);
    send_byte(8'h5A, 1'b1);
    repeat (3) step(1'b0, 2'd0);
    chk8("gaps_strobes", 8'(strobes), 8'd1);
    chk8("gaps_data", last_data, 8'h5A);

    // Reset two symbols into a byte while locked, then relock.
    step(1'b1, 2'd1);
    step(1'b1, 2'd2);
    do_reset();
    repeat (3) send_byte(SYNC, 1'b0);
    chk1("relock_not_yet", bus.active, 1'b0);
    send_byte(SYNC, 1'b0);
    chk1("relock_active", bus.active, 1'b1);
    chk8("relock_strobes", 8'(strobes), 8'd0);

    // Sync byte appearing in the data stream once locked.
    send_byte(SYNC, 1'b0);
    send_byte(8'h11, 1'b0);
    step(1'b0, 2'd0);
`ifdef DROP_SYNC_EN
    chk8("syncdata_strobes", 8'(strobes), 8'd1);
    chk8("syncdata_first", first_data, 8'h11);
`else
    chk8("syncdata_strobes", 8'(strobes), 8'd2);
    chk8("syncdata_first", first_data, 8'hBC);
`endif
    chk8("syncdata_last", last_data, 8'h11);

    // Randomized mix of sync bytes, random bytes, stray symbols, gaps, resets.
    do_reset();
    for (int n = 0; n < 2500; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 1)       do_reset();
      else if (r < 25) send_byte(SYNC, 1'b0);
      else if (r < 40) send_byte(8'($urandom), 1'b0);
      else if (r < 50) step(1'b0, 2'($urandom_range(0, 3)));
      else             step(1'b1, 2'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/byte_deframer_2b.md
# byte_deframer_2b

Downstream consumer of the 2-bit registered mux output. Collects 2-bit symbols, aligns to a repeated sync byte, and once locked emits aligned 8-bit bytes with a one-cycle valid strobe. It is the first byte-wide stage after the 2-bit datapath.

## Interface
- SYNC_BYTE, 8'hBC: alignment pattern, MSB-first on the 2-bit stream.
- SYNC_COUNT, 4: consecutive aligned sync bytes required for lock. Legal range is 1..15.
- clk  in  1  single clock; all state changes on the rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- data_in  in  2  symbol from the upstream mux; bits [1:0] of the byte-in-progress, MSB pair first.
- valid_in  in  1  data_in is a valid symbol this cycle.
- data_out  out  8  last assembled byte; holds between strobes.
- valid_out  out  1  one-cycle strobe; data_out is new this cycle.
- active  out  1  lock achieved; stays high until reset.

## Operation
- Symbols are consumed only on cycles with valid_in=1. Cycles with valid_in=0 change no state: the shift register, symbol counter, sync counter and FSM state all hold.
- Window is the combinational value {shift[5:0], data_in}, where shift holds the previous 3 valid symbols.
- FSM states:
  - **SEARCH** (reset state): on every valid symbol, compare the window against SYNC_BYTE.
    - On a match, set sync_cnt=1 and sym_cnt=0, then go to ALIGN.
    - If SYNC_COUNT==1, a match goes directly to ACTIVE instead.
  - **ALIGN**: sym_cnt counts valid symbols 0..3.
    - On the 4th symbol, if window==SYNC_BYTE, increment sync_cnt. When sync_cnt reaches SYNC_COUNT, go to ACTIVE.
    - If window!=SYNC_BYTE on the 4th symbol, clear sync_cnt and return to SEARCH. Sliding search resumes with the next valid symbol; the failed window is not re-tested.
  - **ACTIVE**: on every 4th valid symbol, window is a complete byte and is presented on data_out with valid_out.
    - The FSM stays in ACTIVE until reset. There is no loss-of-lock detection.
- The sync byte that completes lock is never emitted.
- sym_cnt wraps 3→0. Symbols that are not on a byte boundary produce no output.
- Reset (asynchronous, at any time, including mid-byte or in ACTIVE):
  - data_out=8'h00, valid_out=0, active=0.
  - State=SEARCH; shift, sym_cnt and sync_cnt are cleared.
  - Partial bytes are discarded.

## Timing
- Outputs are registered. valid_out, data_out and the first assertion of active all appear on the clock edge that samples the completing symbol, so they are visible the following cycle.
- Latency is 1 cycle from the last symbol of a byte to its valid_out.
- Maximum throughput is one byte per 4 clocks.
- valid_out is never high on two consecutive cycles.
- active rises on the same edge that sets the state to ACTIVE. valid_out stays 0 on that edge.
- After reset deassertion, the first valid symbol is processed on the next rising edge.

## Configuration
- DROP_SYNC_EN defined: in ACTIVE, bytes equal to SYNC_BYTE are suppressed. No valid_out is generated and data_out holds its previous value.
- DROP_SYNC_EN undefined: every aligned byte in ACTIVE, including SYNC_BYTE, is emitted.
- Lock behaviour is identical in both builds.

## Test plan
All scenarios use default parameters. 0xBC is sent as the symbols 2,3,3,0.
- **Basic lock:** reset, then 4×0xBC followed by 0x5A, all back-to-back.
  - active rises after the 16th symbol.
  - The next valid_out is a single-cycle pulse with data_out=8'h5A.
- **Misalignment:** one leading symbol 1, then 4×0xBC, then 0x3C.
  - Lock succeeds on the shifted boundary.
  - Output is 8'h3C.
- **Broken sync:** 2×0xBC, 0x00, then 4×0xBC and 0xA5.
  - active stays 0 until the final sync completes.
  - A single strobe follows with data_out=8'hA5.
- **Gaps:** basic lock stream with valid_in=0 for 1–3 cycles between random symbols.
  - Identical results to the basic lock test.
  - No extra or missing strobes.
- **Reset mid-operation:** assert reset_L=0 in ACTIVE, two symbols into a byte.
  - Outputs go to 0 immediately and active=0.
  - After release, a full 4×0xBC sequence is needed to relock.
- **Sync in data:** in ACTIVE, send 0xBC then 0x11.
  - With DROP_SYNC_EN: one strobe, 8'h11.
  - Without DROP_SYNC_EN: strobes with 8'hBC, then 8'h11.
